// File: rtl/qif_pkg.sv
// Shared types and arithmetic helpers for the QIF neuron datapath:
// signed current/weight type, clamp limits, saturation and leak.
package qif_pkg;

  localparam int Q_WIDTH = 8;

  typedef logic signed [Q_WIDTH-1:0] cur_t;

  localparam cur_t I_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};
  localparam cur_t I_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};

  function automatic logic sat_hit(input logic signed [31:0] x);
    return (x > 32'(I_MAX)) || (x < 32'(I_MIN));
  endfunction

  function automatic cur_t sat(input logic signed [31:0] x);
    if (x > 32'(I_MAX)) return I_MAX;
    if (x < 32'(I_MIN)) return I_MIN;
    return cur_t'(x[Q_WIDTH-1:0]);
  endfunction

  // Small magnitudes shift to zero leak; force one step toward 0 so the
  // current always settles.
  function automatic cur_t decay(input cur_t x, input int shift);
    cur_t d;
    d = x - (x >>> shift);
    if (x != '0 && d == x)
      d = x[Q_WIDTH-1] ? x + cur_t'(1) : x - cur_t'(1);
    return d;
  endfunction

endpackage

// File: rtl/qif_syn_slot.sv
// One pending-spike entry: holds weight and remaining tick count, fires
// its weight on the tick that finds the count at zero.
module qif_syn_slot
  import qif_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int DLY_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] load_weight,
  input  logic [DLY_W-1:0]        load_delay,
  output logic                    deliver,
  output logic signed [WIDTH-1:0] weight,
  output logic                    occupied
);

  logic [DLY_W-1:0] count;

  // Load only targets a free slot, so a same-cycle tick never sees it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupied <= 1'b0;
      weight   <= '0;
      count    <= '0;
    end else if (load) begin
      occupied <= 1'b1;
      weight   <= load_weight;
      count    <= load_delay;
    end else if (tick && occupied) begin
      if (count == '0)
        occupied <= 1'b0;
      else
        count <= count - 1'b1;
    end
  end

  assign deliver = tick && occupied && (count == '0);

endmodule

// File: rtl/qif_synapse.sv
// Delayed spike-to-current synapse: spikes wait in slots for their axonal
// delay, then add into a leaky, saturating synaptic current on tick.
module qif_synapse
  import qif_pkg::*;
#(
  parameter int WIDTH       = Q_WIDTH,
  parameter int DEPTH       = 4,
  parameter int DLY_W       = 4,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    spike_valid,
  output logic                    spike_ready,
  input  logic signed [WIDTH-1:0] spike_weight,
  input  logic [DLY_W-1:0]        spike_delay,
  output logic signed [WIDTH-1:0] i_syn,
  output logic                    busy,
  output logic                    sat_flag
);

  localparam int ACC_W = WIDTH + $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]        occ;
  logic [DEPTH-1:0]        load;
  logic [DEPTH-1:0]        dlv;
  logic signed [WIDTH-1:0] slot_w [DEPTH];
  logic signed [ACC_W-1:0] dlv_sum;
  logic signed [ACC_W-1:0] next_sum;
  logic                    found;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    qif_syn_slot #(.WIDTH(WIDTH), .DLY_W(DLY_W)) u_slot (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .load        (load[g]),
      .load_weight (spike_weight),
      .load_delay  (spike_delay),
      .deliver     (dlv[g]),
      .weight      (slot_w[g]),
      .occupied    (occ[g])
    );
  end

  assign spike_ready = ~&occ;
  assign busy        = |occ;

  // Lowest-index free slot takes the offered spike.
  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!occ[i] && !found) begin
        load[i] = spike_valid;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    dlv_sum = '0;
    for (int i = 0; i < DEPTH; i++)
      if (dlv[i]) dlv_sum = dlv_sum + ACC_W'(slot_w[i]);
    next_sum = ACC_W'(decay(i_syn, DECAY_SHIFT)) + dlv_sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_syn    <= '0;
      sat_flag <= 1'b0;
    end else if (tick) begin
      i_syn <= sat(32'(next_sum));
      if (sat_hit(32'(next_sum))) sat_flag <= 1'b1;
    end
  end

endmodule

// File: doc/qif_synapse.md
# qif_synapse

Spike-to-current synapse for the QIF neuron datapath. It accepts weighted spike events over a valid/ready handshake and holds each one for a programmable axonal delay. On expiry it adds the weight into a decaying, saturating 8-bit signed synaptic current. That current drives the neuron's synaptic input, so this block is the receiving end of the neuron's spike output.

## Interface
- `WIDTH`, 8: width of weight and current (signed).
- `DEPTH`, 4: number of pending-spike slots.
- `DLY_W`, 4: width of the delay field (max delay 2^DLY_W−1 ticks).
- `DECAY_SHIFT`, 3: leak per tick is i_syn >>> DECAY_SHIFT.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `tick` in 1: neuron time-step strobe, one cycle wide.
- `spike_valid` in 1: spike event offered.
- `spike_ready` out 1: a free slot exists.
- `spike_weight` in WIDTH: signed weight of the offered spike.
- `spike_delay` in DLY_W: delay of the offered spike, in ticks.
- `i_syn` out WIDTH: signed synaptic current, registered.
- `busy` out 1: at least one slot is occupied.
- `sat_flag` out 1: sticky; set when any update saturated.

## Operation
- Slot state per entry: occupied bit, weight, remaining count.
- Accept: `spike_valid && spike_ready` in a cycle writes the lowest-index free slot with count = `spike_delay`.
  - The new entry is not evaluated by a `tick` in that same cycle.
- `spike_ready` = any slot free, computed from registered occupancy only.
  - It never depends on `spike_valid` or `tick`.
  - A slot freed by a tick becomes visible the following cycle.
- On `tick`, occupied slots with count==0 deliver their weight and free. All other occupied slots decrement their count.
- Current update on `tick`: `i_syn ← sat(decay(i_syn) + Σ delivered weights)`.
  - `decay(x) = x − (x >>> DECAY_SHIFT)`, with an arithmetic shift.
  - If x ≠ 0 and that result equals x, decay(x) instead moves x one step toward 0. The current therefore always reaches 0.
  - The sum is computed at WIDTH+clog2(DEPTH)+1 bits, then clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Clamping sets `sat_flag`. Only reset clears it.
- No `tick`: `i_syn` is held and counts are frozen.
- Delay semantics: a spike accepted with delay d is delivered on the (d+1)-th tick after the acceptance cycle.

## Timing
- Reset values:
  - `i_syn` = 0
  - all slots free
  - `spike_ready` = 1
  - `busy` = 0
  - `sat_flag` = 0
- `i_syn`, `busy` and `sat_flag` update at the clock edge of the `tick` or accept cycle. Latency is 1 cycle from the tick to the visible result.
- Full (DEPTH occupied): `spike_ready` = 0. The offered spike is not accepted; the source holds it.
- A simultaneous accept and tick is legal. The tick acts only on entries already present.
- Reset mid-operation: all pending entries are discarded with no delivery, and `i_syn` clears immediately (asynchronous).
- `tick` on consecutive cycles is legal; each one is a full step.

## Structure
- Shared package `qif_pkg`:
  - current/weight typedef (signed WIDTH)
  - `I_MIN` and `I_MAX` constants
  - saturate function
  - decay function
- The neuron block uses the same package for its `V_mem` and `I_syn` types.
- Sub-module `qif_syn_slot`: one entry holding occupied, weight and count. Inputs are load and tick; outputs are deliver, weight and occupied.
- Top level: slot array, free-slot priority encoder, delivered-weight adder tree, current register.

## Test plan
1. Accept w=40, d=0, then three ticks → `i_syn` = 40, 35, 31.
2. Accept w=5, d=0, then six ticks → 5, 4, 3, 2, 1, 0.
   - Repeat with w=−3 → −3, −2, −1, 0.
3. Accept four spikes, w=100, d=2, then three ticks → `i_syn` stays 0, 0, then 127 on the third tick; `sat_flag` = 1 and stays 1.
4. Fill all 4 slots (d=0) without a tick → `spike_ready` = 0 and a 5th offer is not accepted.
   - One tick → `spike_ready` = 1 the next cycle; `busy` = 0.
5. Accept w=20, d=0 in the same cycle as a tick → `i_syn` unchanged that step; it becomes 20 on the next tick.
6. Accept w=60, d=3, tick twice, then assert reset → `i_syn` = 0, `busy` = 0, and no delivery on any subsequent tick.
